// File: rtl/gonso_wb_pkg.sv
// Shared definitions for the gonso Wishbone user-project bus: initiator FSM
// encoding and the responder's address map.
package gonso_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    localparam logic [31:0] GONSO_REG_CTRL = 32'h3003_0004;
    localparam logic [31:0] GONSO_REG_STAT = 32'h3003_0008;
    localparam logic [31:0] GONSO_REG_DATA = 32'h3003_000c;

    // Address bit that selects the responder's memory window over its registers.
    localparam int GONSO_MEM_BIT = 12;

endpackage : gonso_wb_pkg

// File: rtl/wb_timeout_counter.sv
// Ack-wait counter: cleared before a bus cycle, counts while the cycle is
// open, flags expiry when the count reaches TIMEOUT-1.
module wb_timeout_counter #(
    parameter int TIMEOUT = 255,
    parameter int TWIDTH  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TWIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == TWIDTH'(TIMEOUT - 1));

endmodule : wb_timeout_counter

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus
// cycle, one response out, with an ack timeout so a dead responder cannot hang.
module wb_initiator
    import gonso_wb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TWIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:0] wbm_adr_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    wb_state_e   state_reg, state_next;
    logic        req_reg, req_next;
    logic [31:0] adr_reg, adr_next;
    logic        we_reg, we_next;
    logic [31:0] dat_reg, dat_next;
    logic [3:0]  sel_reg, sel_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic        rsp_err_reg, rsp_err_next;
    logic [31:0] rsp_dat_reg, rsp_dat_next;
    logic [7:0]  err_cnt_reg, err_cnt_next;
    logic        tmo_expired;

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .TWIDTH  (TWIDTH)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_reg == IDLE),
        .enable  (state_reg == BUS),
        .expired (tmo_expired)
    );

    always_comb begin
        state_next     = state_reg;
        req_next       = req_reg;
        adr_next       = adr_reg;
        we_next        = we_reg;
        dat_next       = dat_reg;
        sel_next       = sel_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_err_next   = rsp_err_reg;
        rsp_dat_next   = rsp_dat_reg;
        err_cnt_next   = err_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    adr_next   = cmd_adr;
                    we_next    = cmd_we;
                    dat_next   = cmd_dat;
                    sel_next   = cmd_sel;
                    req_next   = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                // Ack is checked first so a last-moment ack beats the timeout.
                if (wbm_ack_i) begin
                    req_next       = 1'b0;
                    rsp_dat_next   = we_reg ? 32'h0 : wbm_dat_i;
                    rsp_err_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end else if (tmo_expired) begin
                    req_next       = 1'b0;
                    rsp_dat_next   = 32'h0;
                    rsp_err_next   = 1'b1;
                    rsp_valid_next = 1'b1;
                    if (err_cnt_reg != 8'hFF) begin
                        err_cnt_next = err_cnt_reg + 8'd1;
                    end
                    state_next     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            req_reg       <= 1'b0;
            adr_reg       <= '0;
            we_reg        <= 1'b0;
            dat_reg       <= '0;
            sel_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_dat_reg   <= '0;
            err_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            req_reg       <= req_next;
            adr_reg       <= adr_next;
            we_reg        <= we_next;
            dat_reg       <= dat_next;
            sel_reg       <= sel_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_dat_reg   <= rsp_dat_next;
            err_cnt_reg   <= err_cnt_next;
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign wbm_cyc_o = req_reg;
    assign wbm_stb_o = req_reg;
    assign wbm_adr_o = adr_reg;
    assign wbm_we_o  = we_reg;
    assign wbm_dat_o = dat_reg;
    assign wbm_sel_o = sel_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_dat   = rsp_dat_reg;
    assign err_cnt   = err_cnt_reg;

endmodule : wb_initiator

// File: tb/tb_wb_initiator.sv
// Randomised bench for wb_initiator against a behavioural memory responder
// with programmable ack delay and a transaction-level reference model.
module tb_wb_initiator;

    localparam int TIMEOUT = 16;
    localparam int TWIDTH  = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic [7:0]  err_cnt;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    always #5 clk = ~clk;

    wb_initiator #(.TIMEOUT(TIMEOUT), .TWIDTH(TWIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    // Responder: ack registered resp_delay cycles into the request
    // (resp_delay = 1 is the gonso responder; 0 never acks).
    int          resp_delay = 1;
    int          resp_cnt = 0;
    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic [31:0] resp_rdata = '0;
    logic [31:0] resp_mem [0:1023];

    always @(posedge clk) begin
        if (!(wbm_cyc_o && wbm_stb_o) || resp_ack) begin
            resp_ack <= 1'b0;
            resp_cnt <= 0;
        end else begin
            if (resp_delay != 0 && resp_cnt == resp_delay - 1) begin
                resp_ack <= 1'b1;
                if (wbm_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (wbm_sel_o[b]) resp_mem[wbm_adr_o[11:2]][8*b +: 8] <= wbm_dat_o[8*b +: 8];
                end else begin
                    resp_rdata <= resp_mem[wbm_adr_o[11:2]];
                end
            end
            resp_cnt <= resp_cnt + 1;
        end
    end

    assign wbm_ack_i = resp_ack | stray_ack;
    assign wbm_dat_i = resp_rdata;

    // Reference model state.
    logic [31:0] ref_mem [0:1023];
    int          ref_err_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int delay, input int hold);
        logic        acked;
        int          exp_stb;
        logic [31:0] exp_dat;
        int          stb_n;
        int          guard;
        acked   = (delay >= 1) && (delay + 1 <= TIMEOUT);
        exp_stb = acked ? delay + 1 : TIMEOUT;
        exp_dat = 32'h0;
        if (acked) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) ref_mem[adr[11:2]][8*b +: 8] = dat[8*b +: 8];
            end else begin
                exp_dat = ref_mem[adr[11:2]];
            end
        end else if (ref_err_cnt < 255) begin
            ref_err_cnt++;
        end

        resp_delay = delay;
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("accept_cyc", {31'h0, wbm_cyc_o}, 32'h1);
        check_eq("bus_adr", wbm_adr_o, adr);
        check_eq("bus_we", {31'h0, wbm_we_o}, {31'h0, we});
        check_eq("bus_dat", wbm_dat_o, dat);
        check_eq("bus_sel", {28'h0, wbm_sel_o}, {28'h0, sel});

        stb_n = 0;
        guard = 0;
        while (!rsp_valid && guard < 200) begin
            if (wbm_stb_o) stb_n++;
            @(negedge clk);
            guard++;
        end
        check_eq("rsp_arrived", {31'h0, rsp_valid}, 32'h1);
        check_eq("stb_cycles", stb_n, exp_stb);
        check_eq("cyc_dropped", {31'h0, wbm_cyc_o}, 32'h0);
        check_eq("rsp_err", {31'h0, rsp_err}, {31'h0, !acked});
        check_eq("rsp_dat", rsp_dat, exp_dat);
        check_eq("err_cnt", {24'h0, err_cnt}, ref_err_cnt);

        for (int h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            cmd_adr = 32'hDEAD_0000;
            check_eq("hold_cmd_ready", {31'h0, cmd_ready}, 32'h0);
            check_eq("hold_valid", {31'h0, rsp_valid}, 32'h1);
            check_eq("hold_dat", rsp_dat, exp_dat);
            check_eq("hold_err", {31'h0, rsp_err}, {31'h0, !acked});
            check_eq("hold_cyc", {31'h0, wbm_cyc_o}, 32'h0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("consumed_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("consumed_ready", {31'h0, cmd_ready}, 32'h1);
        check_eq("consumed_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        $display("txn %0d we=%0d adr=%h dat=%h sel=%h delay=%0d -> rsp_dat=%h err=%0d err_cnt=%0d",
                 n_txn, we, adr, dat, sel, delay, rsp_dat, rsp_err, err_cnt);
        n_txn++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            resp_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_we = 1'b1; cmd_adr = 32'h3003_0004; cmd_dat = 32'h1; cmd_sel = 4'hF;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        check_eq("rst_adr", wbm_adr_o, 32'h0);
        check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed write/readback, byte write, timeout, backpressure, race.
        run_txn(1'b1, 32'h3003_0004, 32'h1234_5678, 4'hF, 1, 0);
        run_txn(1'b0, 32'h3003_0004, 32'h0, 4'hF, 1, 0);
        run_txn(1'b1, 32'h3003_0004, 32'h0000_00FF, 4'h1, 1, 0);
        run_txn(1'b0, 32'h3003_0004, 32'h0, 4'hF, 1, 0);
        check_eq("byte_merge", rsp_dat, 32'h1234_56FF);
        run_txn(1'b0, 32'h3003_0008, 32'h0, 4'hF, 0, 0);
        run_txn(1'b0, 32'h3003_0004, 32'h0, 4'hF, 1, 5);
        run_txn(1'b0, 32'h3003_0004, 32'h0, 4'hF, TIMEOUT - 1, 0);

        // Stray ack while idle must be ignored.
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        @(negedge clk);
        check_eq("stray_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("stray_busy", {31'h0, busy}, 32'h0);

        // Reset while the bus cycle is open.
        resp_delay = 0;
        cmd_we = 1'b0; cmd_adr = 32'h3003_000c; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("pre_rst_stb", {31'h0, wbm_stb_o}, 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ref_err_cnt = 0;
        check_eq("midrst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        check_eq("midrst_stb", {31'h0, wbm_stb_o}, 32'h0);
        check_eq("midrst_adr", wbm_adr_o, 32'h0);
        check_eq("midrst_sel", {28'h0, wbm_sel_o}, 32'h0);
        check_eq("midrst_err_cnt", {24'h0, err_cnt}, 32'h0);
        check_eq("midrst_ready", {31'h0, cmd_ready}, 32'h1);
        repeat (TIMEOUT + 2) @(negedge clk);
        check_eq("midrst_no_rsp", {31'h0, rsp_valid}, 32'h0);
        run_txn(1'b0, 32'h3003_0004, 32'h0, 4'hF, 1, 0);

        // Randomised traffic over the memory window.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            int d;
            a = 32'h3003_1000 | ({22'h0, 10'($urandom_range(0, 15))} << 2);
            d = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TIMEOUT - 1);
            if ($urandom_range(0, 3) != 0 && d > 4) d = 1;
            run_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                    d, $urandom_range(0, 3));
        end

        // Saturation of the error counter.
        for (int t = 0; t < 300; t++) begin
            run_txn(1'b1, 32'h3003_0008, $urandom, 4'hF, 0, 0);
        end
        check_eq("err_cnt_sat", {24'h0, err_cnt}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_wb_initiator
